// File: rtl/adder_arbiter.sv
// Round-robin sequencer that shares one registered adder between NREQ requesters.
// One operation in flight: grant, wait out the adder latency, hold the result until accepted.
module adder_arbiter #(
  parameter  int unsigned N         = 3,
  parameter  int unsigned NREQ      = 2,
  parameter  int unsigned ADDER_LAT = 1,
  localparam int unsigned ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_id,
  output logic [N:0]          resp_sum,
  input  logic                resp_ready,
  output logic [N-1:0]        add_a,
  output logic [N-1:0]        add_b,
  input  logic [N:0]          add_sum,
  output logic                busy
);

  localparam int unsigned LAT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [N-1:0]      add_a_d, add_b_d;
  logic [ID_W-1:0]   resp_id_d;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [N-1:0]      opnd_a [NREQ];
  logic [N-1:0]      opnd_b [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign opnd_a[i] = req_a[i*N +: N];
    assign opnd_b[i] = req_b[i*N +: N];
  end

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NREQ)) begin
        idx = idx - int'(NREQ);
      end
      sel = ID_W'(idx);
      if (!found && req_valid[sel]) begin
        found      = 1'b1;
        win        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lat_cnt <= '0;
      add_a   <= '0;
      add_b   <= '0;
      resp_id <= '0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      lat_cnt <= lat_cnt_d;
      add_a   <= add_a_d;
      add_b   <= add_b_d;
      resp_id <= resp_id_d;
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    lat_cnt_d  = lat_cnt;
    add_a_d    = add_a;
    add_b_d    = add_b;
    resp_id_d  = resp_id;
    req_ready  = '0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (found) begin
          add_a_d   = opnd_a[win];
          add_b_d   = opnd_b[win];
          resp_id_d = win;
          rr_ptr_d  = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
          lat_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        lat_cnt_d = lat_cnt + LAT_W'(1);
        if (lat_cnt == LAT_W'(ADDER_LAT - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The adder operands are frozen outside IDLE, so the sum can pass straight through.
  assign resp_sum = add_sum;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter paired with a one-cycle registered adder model.
module tb_adder_arbiter;

  localparam int unsigned N         = 3;
  localparam int unsigned NREQ      = 2;
  localparam int unsigned ADDER_LAT = 1;
  localparam int unsigned ID_W      = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_id;
  logic [N:0]        resp_sum;
  logic              resp_ready;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic [N:0]        add_sum;
  logic              busy;

  adder_arbiter #(.N(N), .NREQ(NREQ), .ADDER_LAT(ADDER_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_ready(resp_ready), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared adder: sum registered one clock after the operands.
  always_ff @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int id;
    int sum;
    int cyc;
    bit lat_done;
  } exp_t;

  exp_t sb[$];
  int   grant_cnt [NREQ];
  int   resp_cnt  [NREQ];

  initial begin
    for (int i = 0; i < int'(NREQ); i++) begin
      grant_cnt[i] = 0;
      resp_cnt[i]  = 0;
    end
  end

  // Monitor: push on each accept, pop and compare on each response handshake.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (req_ready != '0) begin
        check("onehot", 32'($countones(req_ready)), 1);
        for (int i = 0; i < int'(NREQ); i++) begin
          if (req_valid[i] && req_ready[i]) begin
            sb.push_back('{i, int'(req_a[i*N +: N]) + int'(req_b[i*N +: N]), cyc, 1'b0});
            grant_cnt[i]++;
          end
        end
      end
      if (resp_valid) begin
        check("excl", 32'(req_ready), 0);
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          if (!sb[0].lat_done) begin
            check("latency", 32'(cyc - sb[0].cyc), 1 + ADDER_LAT);
            sb[0].lat_done = 1'b1;
          end
          if (resp_ready) begin
            check("sb_id", 32'(resp_id), 32'(sb[0].id));
            check("sb_sum", 32'(resp_sum), 32'(sb[0].sum));
            resp_cnt[resp_id]++;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int g, output int t);
    bit got;
    got = 1'b0;
    g = -1;
    t = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        t   = cyc;
        for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) g = i;
      end
    end
    check({tag, "_grant_timeout"}, 32'(!got), 0);
  endtask

  task automatic wait_resp(input string tag, output int t);
    bit got;
    got = 1'b0;
    t = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    check({tag, "_resp_timeout"}, 32'(!got), 0);
  endtask

  task automatic wait_idle(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) got = 1'b1;
    end
    check({tag, "_idle_timeout"}, 32'(!got), 0);
  endtask

  initial begin
    int g, t, tr;
    int gs [4];
    int ts [4];
    int g1_before, r1_before;

    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, t, tr;
    int gs [4];
    int ts [4];
    int g1_before, r1_before;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_add_b", 32'(add_b), 0);
    check("rst_id", 32'(resp_id), 0);

    // Basic op: 3 + 5 from requester 0
    tick(); rst = 1'b0;
    req_valid = 2'b01; req_a = {3'd0, 3'd3}; req_b = {3'd0, 3'd5};
    wait_grant("basic", g, t);
    check("basic_ready", 32'(req_ready), 32'b01);
    tick(); req_valid = '0;
    wait_resp("basic", tr);
    check("basic_lat", 32'(tr - t), 2);
    check("basic_sum", 32'(resp_sum), 8);
    check("basic_id", 32'(resp_id), 0);
    wait_idle("basic");

    // Max operands: 7 + 7 from requester 1
    tick(); req_valid = 2'b10; req_a = {3'd7, 3'd0}; req_b = {3'd7, 3'd0};
    wait_grant("max", g, t);
    check("max_grant", 32'(g), 1);
    tick(); req_valid = '0;
    wait_resp("max", tr);
    check("max_sum", 32'(resp_sum), 14);
    check("max_id", 32'(resp_id), 1);
    wait_idle("max");

    // Contention from reset: grants alternate, one accept every ADDER_LAT+2 cycles
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    req_valid = 2'b11; req_a = {3'd4, 3'd1}; req_b = {3'd6, 3'd2};
    for (int k = 0; k < 4; k++) begin
      wait_grant("cont", gs[k], ts[k]);
    end
    for (int k = 0; k < 4; k++) check("cont_order", 32'(gs[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) check("cont_period", 32'(ts[k] - ts[k-1]), ADDER_LAT + 2);
    tick(); req_valid = '0;
    wait_idle("cont");

    // Backpressure: result held for 5 cycles
    tick(); resp_ready = 1'b0; req_valid = 2'b01; req_a = {3'd0, 3'd6}; req_b = {3'd0, 3'd5};
    wait_grant("bp", g, t);
    tick(); req_valid = '0;
    wait_resp("bp", tr);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(resp_valid), 1);
      check("bp_sum", 32'(resp_sum), 11);
      check("bp_id", 32'(resp_id), 0);
      check("bp_ready", 32'(req_ready), 0);
      if (k < 4) @(negedge clk);
    end
    tick(); resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", 32'(busy), 0);
    check("bp_release_valid", 32'(resp_valid), 0);

    // Reset while BUSY: result dropped, round-robin pointer cleared
    tick(); req_valid = 2'b01; req_a = {3'd0, 3'd2}; req_b = {3'd0, 3'd2};
    wait_grant("rmid", g, t);
    check("rmid_grant", 32'(g), 0);
    tick(); rst = 1'b1; req_valid = '0; sb.delete();
    @(negedge clk);
    check("rmid_in_busy", 32'(busy), 1);
    tick();
    @(negedge clk);
    check("rmid_valid", 32'(resp_valid), 0);
    check("rmid_busy", 32'(busy), 0);
    tick(); rst = 1'b0; req_valid = 2'b11; req_a = {3'd1, 3'd1}; req_b = {3'd1, 3'd3};
    wait_grant("rmid2", g, t);
    check("rmid_next_grant", 32'(g), 0);
    tick(); req_valid = '0;
    wait_idle("rmid");

    // Withdrawn request: requester 1 only valid while BUSY
    g1_before = grant_cnt[1];
    r1_before = resp_cnt[1];
    tick(); req_valid = 2'b01; req_a = {3'd5, 3'd4}; req_b = {3'd5, 3'd1};
    wait_grant("wd", g, t);
    check("wd_grant", 32'(g), 0);
    tick(); req_valid = 2'b10;
    @(negedge clk);
    check("wd_busy_ready", 32'(req_ready), 0);
    tick(); req_valid = '0;
    wait_idle("wd");
    check("wd_no_grant1", 32'(grant_cnt[1] - g1_before), 0);
    check("wd_no_resp1", 32'(resp_cnt[1] - r1_before), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
